// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns one pipeline request into native or byte-serial memory accesses.
// Latency: accept -> resp_valid_o at +2 (aligned), +3 (misaligned half), +5 (misaligned word).
// Backpressure: req_ready_o is high only while idle; nothing is queued while a request is in flight.
//
// Ports:
//   clk, rst_i                      clock and synchronous active-high reset
//   req_valid_i/req_ready_o         request handshake; req_we_i, req_addr_i, req_size_i,
//                                   req_unsigned_i, req_wdata_i are latched on acceptance
//   resp_valid_o, resp_data_o       one-cycle completion pulse and load result (0 for stores)
//   mem_rd_en_o, mem_wr_en_o        memory enables, only during the access phase
//   mem_addr_o, mem_wr_data_o       memory byte address and store data
//   mem_load_type_o, mem_store_type_o  access type (LB/LBU/LH/LHU/LW, SB/SH/SW)
//   mem_rd_data_i                   combinational read data from the memory
module lsu_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic [2:0]        mem_load_type_o,
  output logic [1:0]        mem_store_type_o,
  input  logic [31:0]       mem_rd_data_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW  = 3'b100;
  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;

  state_t              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [31:0]         wdata_q;
  logic [1:0]          idx_q;
  logic [31:0]         result_q;
  logic [31:0]         resp_data_q;

  logic                is_byte, is_half, aligned, last_acc;
  logic [1:0]          last_idx;
  logic [4:0]          byte_sh;
  logic [31:0]         wdata_shifted;
  logic [31:0]         merged;
  logic [31:0]         load_val;
  logic [2:0]          native_load;
  logic [1:0]          native_store;

  // Request classification, all from the latched fields.
  always_comb begin
    is_byte  = (size_q == 2'b00);
    is_half  = (size_q == 2'b01);
    aligned  = is_byte | (is_half & ~addr_q[0]) |
               (~is_byte & ~is_half & (addr_q[1:0] == 2'b00));
    last_idx = is_half ? 2'd1 : 2'd3;
    last_acc = aligned | (idx_q == last_idx);

    native_load  = LT_LW;
    native_store = ST_SW;
    if (is_byte) begin
      native_load  = uns_q ? LT_LBU : LT_LB;
      native_store = ST_SB;
    end else if (is_half) begin
      native_load  = uns_q ? LT_LHU : LT_LH;
      native_store = ST_SH;
    end

    byte_sh       = {idx_q, 3'b000};
    wdata_shifted = wdata_q >> byte_sh;
    // Result with byte idx_q replaced by this cycle's read byte.
    merged = (result_q & ~(32'h0000_00FF << byte_sh)) |
             ({24'b0, mem_rd_data_i[7:0]} << byte_sh);

    // Aligned loads come back already extended by the memory; an assembled
    // half needs its own extension from bit 15.
    if (aligned)
      load_val = mem_rd_data_i;
    else if (is_half)
      load_val = {{16{merged[15] & ~uns_q}}, merged[15:0]};
    else
      load_val = merged;
  end

  // Next state and outputs.
  always_comb begin
    state_d          = state_q;
    req_ready_o      = 1'b0;
    resp_valid_o     = 1'b0;
    mem_rd_en_o      = 1'b0;
    mem_wr_en_o      = 1'b0;
    mem_addr_o       = '0;
    mem_wr_data_o    = '0;
    mem_load_type_o  = '0;
    mem_store_type_o = '0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = S_ACC;
      end
      S_ACC: begin
        // Enables are masked by reset so a reset landing in an access cycle
        // suppresses that cycle's write instead of letting it complete.
        mem_rd_en_o = ~we_q & ~rst_i;
        mem_wr_en_o =  we_q & ~rst_i;
        if (aligned) begin
          mem_addr_o       = addr_q;
          mem_wr_data_o    = wdata_q;
          mem_load_type_o  = native_load;
          mem_store_type_o = native_store;
        end else begin
          mem_addr_o       = addr_q + ADDR_W'(idx_q);
          mem_wr_data_o    = {24'b0, wdata_shifted[7:0]};
          mem_load_type_o  = LT_LBU;
          mem_store_type_o = ST_SB;
        end
        if (last_acc) state_d = S_DONE;
      end
      S_DONE: begin
        resp_valid_o = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_data_o = resp_data_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= 2'd0;
      result_q    <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            addr_q   <= req_addr_i;
            size_q   <= req_size_i;
            uns_q    <= req_unsigned_i;
            wdata_q  <= req_wdata_i;
            idx_q    <= 2'd0;
            result_q <= '0;
          end
        end
        S_ACC: begin
          if (!aligned) begin
            result_q <= merged;
            idx_q    <= idx_q + 2'd1;
          end
          if (last_acc) resp_data_q <= we_q ? 32'h0 : load_val;
        end
        default: ;
      endcase
    end
  end

endmodule
